// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and bus-timing constants for the I2C slave
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WR_DATA   = 3'd3,
        WR_ACK    = 3'd4,
        RD_DATA   = 3'd5,
        RD_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } i2c_state_t;

    localparam int SCL_PERIOD_CLK  = 1000;
    localparam int SCL_QUARTER_CLK = 250;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - 2-FF synchronizer with rise/fall pulses on the synchronized value
module i2c_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    // [0],[1] synchronizer stages, [2] previous synchronized value for edge detect
    logic [2:0] r_sr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr <= 3'b111;
        end else begin
            r_sr <= {r_sr[1:0], i_async};
        end
    end

    assign o_sync = r_sr[1];
    assign o_rise = r_sr[1] & ~r_sr[2];
    assign o_fall = ~r_sr[1] & r_sr[2];

endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - open-drain I2C slave, byte read/write with host handshake
// Optional one-hot state LED output enabled by macro I2C_SLAVE_LED_EN.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR = 7'h5A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
`ifdef I2C_SLAVE_LED_EN
    ,
    output logic [15:0] LED
`endif
);

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;

    i2c_sync_edge u_scl_sync (
        .clk(clk), .reset(reset), .i_async(SCL),
        .o_sync(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk(clk), .reset(reset), .i_async(SDA),
        .o_sync(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
    );

    i2c_state_t r_state, w_state_nxt;
    logic [3:0] r_bit_cnt, w_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [7:0] r_rx_data, w_rx_data_nxt;
    logic       r_sda_oe, w_oe_nxt;
    logic       r_rx_valid, w_rx_valid_nxt;
    logic       r_tx_req, w_tx_req_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_mack, w_mack_nxt;

    logic       w_start, w_stop;
    logic [7:0] w_shift_in;

    assign w_start    = w_sda_fall & w_scl;
    assign w_stop     = w_sda_rise & w_scl;
    assign w_shift_in = {r_shift[6:0], w_sda};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'h00;
            r_rx_data  <= 8'h00;
            r_sda_oe   <= 1'b0;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_busy     <= 1'b0;
            r_mack     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_sda_oe   <= w_oe_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_tx_req   <= w_tx_req_nxt;
            r_busy     <= w_busy_nxt;
            r_mack     <= w_mack_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_rx_data_nxt  = r_rx_data;
        w_oe_nxt       = r_sda_oe;
        w_rx_valid_nxt = 1'b0;
        w_tx_req_nxt   = 1'b0;
        w_busy_nxt     = r_busy;
        w_mack_nxt     = r_mack;

        if (w_start) begin
            w_state_nxt = ADDR;
            w_cnt_nxt   = 4'd0;
            w_shift_nxt = 8'h00;
            w_oe_nxt    = 1'b0;
            w_mack_nxt  = 1'b0;
        end else if (w_stop) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 4'd0;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
            w_mack_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                ADDR: if (w_scl_rise) begin
                    w_shift_nxt = w_shift_in;
                    w_cnt_nxt   = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd7) begin
                        w_cnt_nxt = 4'd0;
                        if (w_shift_in[7:1] == SLV_ADDR) begin
                            w_state_nxt = ADDR_ACK;
                            w_busy_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = WAIT_STOP;
                        end
                    end
                end
                // First falling edge starts the ACK, second ends it; r_shift[0] still holds R/W.
                ADDR_ACK: if (w_scl_fall) begin
                    if (!r_sda_oe) begin
                        w_oe_nxt = 1'b1;
                    end else if (r_shift[0]) begin
                        w_shift_nxt  = tx_data;
                        w_oe_nxt     = ~tx_data[7];
                        w_tx_req_nxt = 1'b1;
                        w_state_nxt  = RD_DATA;
                    end else begin
                        w_oe_nxt    = 1'b0;
                        w_state_nxt = WR_DATA;
                    end
                end
                WR_DATA: if (w_scl_rise) begin
                    w_shift_nxt = w_shift_in;
                    w_cnt_nxt   = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd7) begin
                        w_cnt_nxt      = 4'd0;
                        w_rx_data_nxt  = w_shift_in;
                        w_rx_valid_nxt = 1'b1;
                        w_state_nxt    = WR_ACK;
                    end
                end
                WR_ACK: if (w_scl_fall) begin
                    w_oe_nxt = ~r_sda_oe;
                    if (r_sda_oe) w_state_nxt = WR_DATA;
                end
                RD_DATA: begin
                    if (w_scl_rise) begin
                        w_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_oe_nxt    = 1'b0;
                            w_cnt_nxt   = 4'd0;
                            w_state_nxt = RD_ACK;
                        end else begin
                            w_oe_nxt    = ~r_shift[6];
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                        end
                    end
                end
                RD_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda) w_state_nxt = WAIT_STOP;
                        else       w_mack_nxt  = 1'b1;
                    end else if (w_scl_fall && r_mack) begin
                        w_shift_nxt  = tx_data;
                        w_oe_nxt     = ~tx_data[7];
                        w_tx_req_nxt = 1'b1;
                        w_mack_nxt   = 1'b0;
                        w_state_nxt  = RD_DATA;
                    end
                end
                default: w_oe_nxt = 1'b0;
            endcase
        end
    end

    assign SDA      = r_sda_oe ? 1'b0 : 1'bz;
    assign tx_req   = r_tx_req;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;

`ifdef I2C_SLAVE_LED_EN
    logic [15:0] r_led;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_led <= 16'h0001;
        else        r_led <= 16'h0001 << w_state_nxt;
    end

    assign LED = r_led;
`endif

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - directed self-checking bench for i2c_slave with scoreboard queues
module tb_i2c_slave;
    import i2c_pkg::*;

    // Bus runs 5x faster than the nominal timing to keep the run short.
    localparam int Q = SCL_QUARTER_CLK / 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       m_low;
    logic [7:0] tx_data;
    logic       tx_req, rx_valid, busy;
    logic [7:0] rx_data;
    wire        sda_bus;

    always #5 clk = ~clk;

    pullup (sda_bus);
    assign sda_bus = m_low ? 1'b0 : 1'bz;

    i2c_slave #(.SLV_ADDR(7'h5A)) dut (
        .clk(clk), .reset(reset), .SCL(scl), .SDA(sda_bus),
        .tx_data(tx_data), .tx_req(tx_req), .rx_data(rx_data),
        .rx_valid(rx_valid), .busy(busy)
    );

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] host_q[$];
    int         rx_valid_cnt = 0;
    int         tx_req_cnt = 0;
    logic       mon_en = 1'b0;
    logic       slave_drove = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_low = 1'b0; wq();
        scl = 1'b1;   wq();
        m_low = 1'b1; wq();
        scl = 1'b0;   wq();
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; wq();
        scl = 1'b1;   wq();
        m_low = 1'b0; wq();
    endtask

    task automatic put_bit(input logic b, output logic s);
        m_low = ~b; wq();
        scl = 1'b1; wq();
        s = sda_bus; wq();
        scl = 1'b0; wq();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) put_bit(d[i], s);
        put_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            put_bit(1'b1, s);
            d[i] = s;
        end
        put_bit(nack, s);
    endtask

    // Host side: rx scoreboard and tx_data supply.
    initial forever begin
        @(negedge clk);
        if (rx_valid) begin
            rx_valid_cnt++;
            check("rx_valid_expected", 32'(exp_rx_q.size() != 0), 1);
            if (exp_rx_q.size() != 0) check("rx_data_sb", rx_data, exp_rx_q.pop_front());
        end
        if (tx_req) begin
            tx_req_cnt++;
            if (host_q.size() != 0) tx_data = host_q.pop_front();
        end
    end

    initial forever begin
        @(posedge clk);
        if (mon_en && !m_low && sda_bus === 1'b0) slave_drove = 1'b1;
    end

    initial begin
        logic       ack, s;
        logic [7:0] d;

        reset = 1'b0; scl = 1'b1; m_low = 1'b0; tx_data = 8'h00;
        repeat (5) @(negedge clk);
        check("rst_sda", sda_bus, 1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_req", tx_req, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // master write
        i2c_start();
        send_byte(8'hB4, ack);
        check("wr_addr_ack", ack, 0);
        check("wr_busy", busy, 1);
        exp_rx_q.push_back(8'h3C);
        send_byte(8'h3C, ack);
        check("wr_data_ack", ack, 0);
        i2c_stop(); wq();
        check("wr_rx_data", rx_data, 8'h3C);
        check("wr_rx_cnt", rx_valid_cnt, 1);
        check("wr_busy_after_stop", busy, 0);

        // address mismatch
        mon_en = 1'b1;
        i2c_start();
        send_byte(8'hA0, ack);
        check("mm_addr_nack", ack, 1);
        send_byte(8'h55, ack);
        check("mm_data_nack", ack, 1);
        mon_en = 1'b0;
        check("mm_sda_never_driven", slave_drove, 0);
        check("mm_busy", busy, 0);
        i2c_stop(); wq();
        check("mm_rx_cnt", rx_valid_cnt, 1);

        // master read, 4 bytes
        tx_data = 8'h11;
        host_q = '{8'h22, 8'h33, 8'h44};
        exp_rd_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        tx_req_cnt = 0;
        i2c_start();
        send_byte(8'hB5, ack);
        check("rd_addr_ack", ack, 0);
        for (int i = 0; i < 4; i++) begin
            recv_byte(i == 3, d);
            check("rd_byte", d, exp_rd_q.pop_front());
        end
        check("rd_tx_req_cnt", tx_req_cnt, 4);
        recv_byte(1'b1, d);
        check("rd_wait_stop_released", d, 8'hFF);
        check("rd_tx_req_cnt_after", tx_req_cnt, 4);
        check("rd_busy_wait_stop", busy, 1);
        i2c_stop(); wq();
        check("rd_busy_after_stop", busy, 0);

        // repeated START: write then read
        exp_rx_q.push_back(8'h01);
        i2c_start();
        send_byte(8'hB4, ack);
        check("rs_wr_addr_ack", ack, 0);
        send_byte(8'h01, ack);
        check("rs_wr_data_ack", ack, 0);
        tx_data = 8'h77;
        i2c_start();
        check("rs_busy_held", busy, 1);
        send_byte(8'hB5, ack);
        check("rs_rd_addr_ack", ack, 0);
        check("rs_rx_data", rx_data, 8'h01);
        recv_byte(1'b1, d);
        check("rs_rd_byte", d, 8'h77);
        i2c_stop(); wq();
        check("rs_rx_cnt", rx_valid_cnt, 2);

        // reset during the 5th bit of a read byte (0xF0: 5th bit is 0)
        tx_data = 8'hF0;
        i2c_start();
        send_byte(8'hB5, ack);
        check("rr_addr_ack", ack, 0);
        for (int i = 0; i < 4; i++) put_bit(1'b1, s);
        m_low = 1'b0; wq();
        scl = 1'b1; wq();
        check("rr_bit5_driven", sda_bus, 0);
        reset = 1'b0;
        #1;
        check("rr_sda_released", sda_bus, 1);
        check("rr_rx_data", rx_data, 8'h00);
        check("rr_rx_valid", rx_valid, 0);
        check("rr_tx_req", tx_req, 0);
        check("rr_busy", busy, 0);
        wq();
        reset = 1'b1;
        wq(); scl = 1'b0; wq(); scl = 1'b1; wq();
        exp_rx_q.push_back(8'h5A);
        i2c_start();
        send_byte(8'hB4, ack);
        check("rr_next_addr_ack", ack, 0);
        send_byte(8'h5A, ack);
        check("rr_next_data_ack", ack, 0);
        i2c_stop(); wq();
        check("rr_next_rx_data", rx_data, 8'h5A);
        check("rr_next_busy", busy, 0);

        // STOP after 4 bits of a write byte
        i2c_start();
        send_byte(8'hB4, ack);
        check("sa_addr_ack", ack, 0);
        put_bit(1'b0, s); put_bit(1'b0, s); put_bit(1'b1, s); put_bit(1'b1, s);
        i2c_stop(); wq();
        check("sa_rx_cnt", rx_valid_cnt, 3);
        check("sa_rx_data", rx_data, 8'h5A);
        check("sa_busy", busy, 0);
        check("sa_sda", sda_bus, 1);
        check("sa_rx_q_empty", exp_rx_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter SLV_ADDR, default 7'h5A: 7-bit bus address the block responds to.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 SCL  input  1  bus clock driven by the master; no clock stretching.
REQ-005 SDA  inout  1  bus data; the block SHALL only drive 0 or release to Z (open-drain).
REQ-006 tx_data  input  8  byte to return on a master read; sampled when tx_req pulses.
REQ-007 tx_req  output  1  one-cycle pulse when tx_data is loaded into the shift register.
REQ-008 rx_data  output  8  last byte written by the master.
REQ-009 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-010 busy  output  1  high from a START with address match until STOP or reset.

Function
REQ-011 SCL and SDA SHALL pass through 2-FF synchronizers; edges SHALL be detected on the synchronized values.
REQ-012 START = synchronized SDA falls while SCL is high; STOP = SDA rises while SCL is high; both are detected in any state.
REQ-013 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-014 START (including repeated START) -> ADDR with bit counter 0 and SDA released; STOP -> IDLE with SDA released and busy=0.
REQ-015 Each data/address bit SHALL be sampled on the SCL rising edge, MSB first; SDA SHALL change only on SCL falling edges.
REQ-016 ADDR: after 8 bits, if byte[7:1]==SLV_ADDR -> ADDR_ACK with busy=1, else -> WAIT_STOP with SDA released (NACK).
REQ-017 ACK: SDA SHALL be driven 0 from the SCL falling edge after bit 8 to the SCL falling edge after bit 9.
REQ-018 After ADDR_ACK: R/W=0 -> WR_DATA; R/W=1 -> RD_DATA, with tx_data loaded and tx_req pulsed on the falling edge that ends the ACK.
REQ-019 WR_DATA: on the 8th SCL rising edge, rx_data SHALL update and rx_valid SHALL pulse on the next clk; then WR_ACK (always ACK), then WR_DATA.
REQ-020 RD_DATA: drive 0 for a 0 bit, release for a 1 bit; after 8 bits release SDA -> RD_ACK.
REQ-021 RD_ACK: master SDA sampled on the SCL rising edge; 0 -> reload tx_data and pulse tx_req on the next SCL falling edge -> RD_DATA; 1 (NACK) -> WAIT_STOP.
REQ-022 WAIT_STOP: SDA released; only START or STOP leaves this state.
REQ-023 A START or STOP during any byte SHALL abort the byte: no rx_valid pulse and SDA released within 3 clk.

Reset
REQ-024 On reset low: state=IDLE, SDA=Z, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, shift register and bit counter 0, synchronizers set to 1.
REQ-025 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously); after release the block ignores the bus until the next START.

Configuration
REQ-026 Macro I2C_SLAVE_LED_EN defined: add output LED[15:0], a one-hot state indicator (bit index = state encoding), registered.
REQ-027 Macro I2C_SLAVE_LED_EN undefined: no LED port and no LED logic.

Structure
REQ-028 Package i2c_pkg SHALL hold the slave state enumeration and shared bus-timing constants (SCL period 1000 clk, quarter 250).
REQ-029 Sub-module i2c_sync_edge (2-FF synchronizer plus rise/fall pulse) SHALL be instantiated once each for SCL and SDA.

Verification
REQ-030 Master write: START, 0xB4, 0x3C, STOP -> ACK on both bytes; rx_data=0x3C with one rx_valid pulse; busy returns to 0 after STOP.
REQ-031 Address mismatch: START, 0xA0, 0x55 -> SDA never driven by the slave; no rx_valid; busy=0.
REQ-032 Master read, 4 bytes: START, 0xB5; host supplies 0x11, 0x22, 0x33, 0x44 on each tx_req; master ACK x3 then NACK -> bus carries 0x11..0x44; exactly 4 tx_req pulses; then WAIT_STOP.
REQ-033 Repeated START: write 0xB4, 0x01, then START, 0xB5 read -> rx_data=0x01; read phase entered without an intervening STOP.
REQ-034 Reset asserted during the 5th bit of a read byte -> SDA=Z the same cycle; all outputs at reset values; the next full transaction completes correctly.
REQ-035 STOP injected after 4 bits of a write byte -> no rx_valid pulse; state IDLE; busy=0.
